// File: rtl/h3_pkg.sv
// Shared widths, FSM states and offset helpers for the H3 hash pipeline.
package h3_pkg;

    localparam int unsigned DEF_NUMBER_OF_TABLES = 4;
    localparam int unsigned DEF_HASH_ADR_WIDTH   = 5;
    localparam int unsigned DEF_KEY_WIDTH        = 6;
    localparam int unsigned DEF_OP_WIDTH         = 2;

    typedef enum logic [1:0] {
        UNLOADED = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2,
        CAPTURE  = 2'd3
    } h3_state_e;

    // Bit offset of matrix row [tbl][row] in the flattened matrix bundle.
    function automatic int unsigned row_offset(input int unsigned tbl, input int unsigned row,
                                               input int unsigned adr_w, input int unsigned key_w);
        return (tbl * adr_w + row) * key_w;
    endfunction

    // Bit offset of table tbl's address slice in the flattened address bus.
    function automatic int unsigned adr_offset(input int unsigned tbl, input int unsigned adr_w);
        return tbl * adr_w;
    endfunction

endpackage

// File: rtl/h3_row_reduce.sv
// One table's XOR-reduction: address bit j is the parity of the row-j key/matrix product.
module h3_row_reduce
    import h3_pkg::*;
#(
    parameter int unsigned HASH_ADR_WIDTH = DEF_HASH_ADR_WIDTH,
    parameter int unsigned KEY_WIDTH      = DEF_KEY_WIDTH
) (
    input  logic [HASH_ADR_WIDTH*KEY_WIDTH-1:0] prod,
    output logic [HASH_ADR_WIDTH-1:0]           adr_c
);

    always_comb begin
        adr_c = '0;
        for (int j = 0; j < int'(HASH_ADR_WIDTH); j++) begin
            adr_c[j] = ^prod[row_offset(0, j, HASH_ADR_WIDTH, KEY_WIDTH) +: KEY_WIDTH];
        end
    end

endmodule

// File: rtl/h3_hash_pipeline.sv
// Two-stage valid/ready H3 hash pipeline with shadowed matrices and a drain-before-reload FSM.
module h3_hash_pipeline
    import h3_pkg::*;
#(
    parameter int unsigned NUMBER_OF_TABLES = DEF_NUMBER_OF_TABLES,
    parameter int unsigned HASH_ADR_WIDTH   = DEF_HASH_ADR_WIDTH,
    parameter int unsigned KEY_WIDTH        = DEF_KEY_WIDTH,
    parameter int unsigned OP_WIDTH         = DEF_OP_WIDTH
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH*KEY_WIDTH-1:0] matrixes_i,
    input  logic                                             matrix_load_i,
    output logic                                             matrix_ready_o,
    input  logic                                             in_valid_i,
    output logic                                             in_ready_o,
    input  logic [KEY_WIDTH-1:0]                             key_i,
    input  logic [OP_WIDTH-1:0]                              op_i,
    output logic                                             out_valid_o,
    input  logic                                             out_ready_i,
    output logic [NUMBER_OF_TABLES*HASH_ADR_WIDTH-1:0]       adr_o,
    output logic [KEY_WIDTH-1:0]                             key_o,
    output logic [OP_WIDTH-1:0]                              op_o
);

    localparam int unsigned ROWS  = NUMBER_OF_TABLES * HASH_ADR_WIDTH;
    localparam int unsigned MAT_W = ROWS * KEY_WIDTH;
    localparam int unsigned TBL_W = HASH_ADR_WIDTH * KEY_WIDTH;

    h3_state_e             state_q, state_d;
    logic                  capture_c;
    logic [MAT_W-1:0]      shadow_q;
    logic                  s1_valid_q;
    logic [KEY_WIDTH-1:0]  s1_key_q;
    logic [OP_WIDTH-1:0]   s1_op_q;
    logic [MAT_W-1:0]      s1_prod_q;
    logic [ROWS-1:0]       adr_c;
    logic                  s2_advance, s1_advance, in_hs;

    assign s2_advance     = !out_valid_o || out_ready_i;
    assign s1_advance     = s1_valid_q && s2_advance;
    assign in_hs          = in_valid_i && in_ready_o;
    assign matrix_ready_o = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= UNLOADED;
        else        state_q <= state_d;
    end

    // A load request in RUN closes the input immediately so no key sees mixed matrices.
    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        capture_c  = 1'b0;
        case (state_q)
            UNLOADED: begin
                if (matrix_load_i) state_d = CAPTURE;
            end
            RUN: begin
                if (matrix_load_i) state_d = DRAIN;
                else               in_ready_o = !s1_valid_q || s1_advance;
            end
            DRAIN: begin
                if (!s1_valid_q && !out_valid_o) state_d = CAPTURE;
            end
            CAPTURE: begin
                capture_c = 1'b1;
                state_d   = RUN;
            end
            default: state_d = UNLOADED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)         shadow_q <= '0;
        else if (capture_c) shadow_q <= matrixes_i;
    end

    // Stage 1: key, op and the key ANDed into every matrix row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_key_q   <= '0;
            s1_op_q    <= '0;
            s1_prod_q  <= '0;
        end else if (in_hs) begin
            s1_valid_q <= 1'b1;
            s1_key_q   <= key_i;
            s1_op_q    <= op_i;
            s1_prod_q  <= shadow_q & {ROWS{key_i}};
        end else if (s1_advance) begin
            s1_valid_q <= 1'b0;
        end
    end

    for (genvar t = 0; t < int'(NUMBER_OF_TABLES); t++) begin : g_tbl
        h3_row_reduce #(
            .HASH_ADR_WIDTH (HASH_ADR_WIDTH),
            .KEY_WIDTH      (KEY_WIDTH)
        ) u_reduce (
            .prod  (s1_prod_q[row_offset(t, 0, HASH_ADR_WIDTH, KEY_WIDTH) +: TBL_W]),
            .adr_c (adr_c[adr_offset(t, HASH_ADR_WIDTH) +: HASH_ADR_WIDTH])
        );
    end

    // Stage 2: parity bits plus sideband; only reloads when S1 actually holds a key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            adr_o       <= '0;
            key_o       <= '0;
            op_o        <= '0;
        end else if (s2_advance) begin
            out_valid_o <= s1_valid_q;
            if (s1_valid_q) begin
                adr_o <= adr_c;
                key_o <= s1_key_q;
                op_o  <= s1_op_q;
            end
        end
    end

endmodule
